// File: rtl/sensor_warn_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : sensor_warn_scheduler                                          |
// | Desc     : Round-robin scheduler sharing one sensor sampling port and one |
// |            signed threshold comparator among NCH sensor channels, with   |
// |            per-channel debounced warning flags and programmable          |
// |            thresholds. Optional macro WARN_TIMEOUT_EN adds a per-request |
// |            ack timeout that raises a per-channel fault flag.             |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module sensor_warn_scheduler #(
   parameter int                 NCH         = 4,
   parameter int                 DEBOUNCE    = 3,
   parameter logic signed [31:0] THR_DEFAULT = 32'sd10,
   parameter int                 TIMEOUT     = 16,
   localparam int                SELW        = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                    clock,
   input  logic                    reset,
   output logic                    sample_req,
   output logic [SELW-1:0]         sample_sel,
   input  logic                    sample_ack,
   input  logic signed [31:0]      sample_data,
   input  logic                    cfg_we,
   input  logic [SELW-1:0]         cfg_addr,
   input  logic signed [31:0]      cfg_data,
   output logic [NCH-1:0]          warn,
   output logic                    warn_any,
   output logic [NCH-1:0]          fault,
   output logic                    scan_done
);

   // Debounce counter wide enough for DEBOUNCE up to 15.
   localparam int CW = 4;

   // Reject out-of-range configurations at elaboration time.
   if (NCH < 2 || NCH > 8 || DEBOUNCE < 1 || DEBOUNCE > 15 || TIMEOUT < 1) begin : g_param_check
      $error("sensor_warn_scheduler: parameter out of range");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_CMP  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [SELW-1:0]         ch_q, ch_d;
   logic signed [31:0]      data_q, data_d;
   logic signed [31:0]      thr_q [NCH];
   logic signed [31:0]      thr_d [NCH];
   logic [CW-1:0]           cnt_q [NCH];
   logic [CW-1:0]           cnt_d [NCH];
   logic [NCH-1:0]          warn_q, warn_d;
   logic                    warn_any_q;
   logic                    low;

`ifdef WARN_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]           wait_q, wait_d;
   logic                    tout_q, tout_d;
   logic [NCH-1:0]          fault_q, fault_d;
`endif

   // Next-state, datapath and flag update for the scan FSM.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      data_d  = data_q;
      thr_d   = thr_q;
      cnt_d   = cnt_q;
      warn_d  = warn_q;
`ifdef WARN_TIMEOUT_EN
      wait_d  = wait_q;
      tout_d  = tout_q;
      fault_d = fault_q;
`endif
      // Compare against the threshold as it stood before any write this cycle.
      low = (data_q < thr_q[ch_q]);

      // Threshold writes; addresses with no matching channel fall through.
      for (int i = 0; i < NCH; i++) begin
         if (cfg_we && (cfg_addr == SELW'(i))) begin
            thr_d[i] = cfg_data;
         end
      end

      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            ch_d    = '0;
`ifdef WARN_TIMEOUT_EN
            wait_d  = '0;
            tout_d  = 1'b0;
`endif
         end
         S_REQ: begin
            if (sample_ack) begin
               data_d  = sample_data;
               state_d = S_CMP;
`ifdef WARN_TIMEOUT_EN
               tout_d  = 1'b0;
            end else if (wait_q == TW'(TIMEOUT - 1)) begin
               // Give up on this channel; CMP then acts as the timeout cycle.
               state_d = S_CMP;
               tout_d  = 1'b1;
            end else begin
               wait_d  = wait_q + 1'b1;
`endif
            end
         end
         S_CMP: begin
            state_d = S_REQ;
            ch_d    = (ch_q == SELW'(NCH - 1)) ? '0 : ch_q + 1'b1;
`ifdef WARN_TIMEOUT_EN
            wait_d  = '0;
            if (tout_q) begin
               fault_d[ch_q] = 1'b1;
            end else begin
               fault_d[ch_q] = 1'b0;
`endif
               if (low == warn_q[ch_q]) begin
                  cnt_d[ch_q] = '0;
               end else if (cnt_q[ch_q] == CW'(DEBOUNCE - 1)) begin
                  warn_d[ch_q] = ~warn_q[ch_q];
                  cnt_d[ch_q]  = '0;
               end else begin
                  cnt_d[ch_q] = cnt_q[ch_q] + 1'b1;
               end
`ifdef WARN_TIMEOUT_EN
            end
`endif
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ch_q       <= '0;
         data_q     <= '0;
         warn_q     <= '0;
         warn_any_q <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            thr_q[i] <= THR_DEFAULT;
            cnt_q[i] <= '0;
         end
`ifdef WARN_TIMEOUT_EN
         wait_q     <= '0;
         tout_q     <= 1'b0;
         fault_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         data_q     <= data_d;
         warn_q     <= warn_d;
         warn_any_q <= |warn_d;
         thr_q      <= thr_d;
         cnt_q      <= cnt_d;
`ifdef WARN_TIMEOUT_EN
         wait_q     <= wait_d;
         tout_q     <= tout_d;
         fault_q    <= fault_d;
`endif
      end
   end

   assign sample_req = (state_q == S_REQ);
   assign sample_sel = ch_q;
   assign warn       = warn_q;
   assign warn_any   = warn_any_q;
   assign scan_done  = (state_q == S_CMP) && (ch_q == SELW'(NCH - 1));
`ifdef WARN_TIMEOUT_EN
   assign fault      = fault_q;
`else
   assign fault      = '0;
`endif

endmodule
`default_nettype wire
